// File: rtl/registers_rx_frame_if.sv
// Byte-stream RX handshake between a byte source (master) and the frame receiver (slave).
// The source holds rx_data stable while rx_rdy=1 and drops rx_rdy when rx_ack is seen.
interface registers_rx_frame_if #(
  parameter int RX_DATA_WIDTH = 8
);
  logic [RX_DATA_WIDTH-1:0] rx_data;
  logic                     rx_rdy;
  logic                     rx_ack;

  modport master (output rx_data, output rx_rdy, input rx_ack);
  modport slave  (input rx_data, input rx_rdy, output rx_ack);
endinterface

// File: rtl/registers_rx_frame.sv
// Assembles address/data/checksum frames from an RX byte stream, commits good frames to the
// register bus, discards bad or stalled frames, and drives a pulse/level request vector.
module registers_rx_frame #(
  parameter int                RX_DATA_WIDTH    = 8,
  parameter int                REG_ADDR_WIDTH   = 8,
  parameter int                REG_DATA_WIDTH   = 16,
  parameter int                N_RQST           = 6,
  parameter int                ADDR_REQUESTS    = 0,
  parameter logic [N_RQST-1:0] DEFAULT_REQUESTS = '0,
  parameter logic [N_RQST-1:0] LEVEL_MASK       = '0,
  parameter int                TIMEOUT_CYCLES   = 1024,
  parameter int                CHECKSUM_EN      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  registers_rx_frame_if.slave       rx,
  output logic [REG_ADDR_WIDTH-1:0] register_addr,
  output logic [REG_DATA_WIDTH-1:0] register_data,
  output logic                      register_rdy,
  output logic [N_RQST-1:0]         rqst_o,
  output logic                      err_checksum,
  output logic                      err_timeout,
  output logic [7:0]                err_count
);

  localparam int AB      = (REG_ADDR_WIDTH + RX_DATA_WIDTH - 1) / RX_DATA_WIDTH;
  localparam int DB      = (REG_DATA_WIDTH + RX_DATA_WIDTH - 1) / RX_DATA_WIDTH;
  localparam int AW      = AB * RX_DATA_WIDTH;
  localparam int DW      = DB * RX_DATA_WIDTH;
  localparam int CNT_MAX = (AB > DB) ? AB : DB;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0]             AB_LAST  = CW'(AB - 1);
  localparam logic [CW-1:0]             DB_LAST  = CW'(DB - 1);
  localparam logic [TW-1:0]             T_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [REG_ADDR_WIDTH-1:0] REQ_ADDR = REG_ADDR_WIDTH'(ADDR_REQUESTS);

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_CSUM} state_t;

  state_t                   state;
  logic [CW-1:0]            byte_cnt;
  logic [AW-1:0]            addr_sr;
  logic [DW-1:0]            data_sr;
  logic [RX_DATA_WIDTH-1:0] xor_acc;
  logic [TW-1:0]            idle_cnt;

  logic                     capture;
  logic                     mid_frame;
  logic                     timeout_hit;
  logic [AW-1:0]            addr_next;
  logic [DW-1:0]            data_next;
  logic [RX_DATA_WIDTH-1:0] xor_next;

  // The ack register blocks the edge right after a capture, giving the 2-cycle byte rate.
  always_comb begin
    capture     = rx.rx_rdy && !rx.rx_ack;
    addr_next   = (addr_sr << RX_DATA_WIDTH) | AW'(rx.rx_data);
    data_next   = (data_sr << RX_DATA_WIDTH) | DW'(rx.rx_data);
    xor_next    = xor_acc ^ rx.rx_data;
    mid_frame   = (byte_cnt != '0) || (state != S_ADDR);
    timeout_hit = (TIMEOUT_CYCLES != 0) && mid_frame && !capture && (idle_cnt == T_LAST);
  end

  // NOTE: every register here is a plain flop (no memory array), so all of it is reset;
  // non-blocking assignments keep each edge reading the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_ADDR;
      byte_cnt      <= '0;
      addr_sr       <= '0;
      data_sr       <= '0;
      xor_acc       <= '0;
      idle_cnt      <= '0;
      rx.rx_ack     <= 1'b0;
      register_addr <= '0;
      register_data <= '0;
      register_rdy  <= 1'b0;
      rqst_o        <= DEFAULT_REQUESTS & LEVEL_MASK;
      err_checksum  <= 1'b0;
      err_timeout   <= 1'b0;
      err_count     <= '0;
    end else begin
      rx.rx_ack    <= capture;
      register_rdy <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;

      // Requests follow the commit strobe by one cycle; pulse bits clear themselves.
      if (register_rdy && register_addr == REQ_ADDR) rqst_o <= register_data[N_RQST-1:0];
      else                                           rqst_o <= rqst_o & LEVEL_MASK;

      if (capture) begin
        idle_cnt <= '0;
        xor_acc  <= xor_next;
        unique case (state)
          S_ADDR: begin
            addr_sr <= addr_next;
            if (byte_cnt == AB_LAST) begin
              byte_cnt <= '0;
              state    <= S_DATA;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_DATA: begin
            data_sr <= data_next;
            if (byte_cnt == DB_LAST) begin
              byte_cnt <= '0;
              if (CHECKSUM_EN != 0) begin
                state <= S_CSUM;
              end else begin
                state         <= S_ADDR;
                xor_acc       <= '0;
                register_addr <= addr_sr[REG_ADDR_WIDTH-1:0];
                register_data <= data_next[REG_DATA_WIDTH-1:0];
                register_rdy  <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_CSUM: begin
            state   <= S_ADDR;
            xor_acc <= '0;
            if (xor_next == '0) begin
              register_addr <= addr_sr[REG_ADDR_WIDTH-1:0];
              register_data <= data_sr[REG_DATA_WIDTH-1:0];
              register_rdy  <= 1'b1;
            end else begin
              err_checksum <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          default: state <= S_ADDR;
        endcase
      end else if (timeout_hit) begin
        state       <= S_ADDR;
        byte_cnt    <= '0;
        xor_acc     <= '0;
        idle_cnt    <= '0;
        err_timeout <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (mid_frame) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
